usb2_ulpi_reg_arb: RTL and testbench
====================================

Name: usb2_ulpi_reg_arb

Overview:
- Round-robin arbiter for the ULPI PHY register read/write path.
- Lets several requesters share the single register-access command port of the ULPI core; typical requesters are link control, HS chirp/config and debug.
- Issues exactly one register transaction at a time and holds off while the packet layer owns the bus.
- Returns read data, a done pulse and a timeout error to the granted requester only.

Parameters:
- NUM_REQ, 3: number of requesters (2..8).
- TIMEOUT, 255: cycles to wait for reg_ack before aborting (1..2^TO_W-1).
- TO_W, 8: width of the timeout counter.

Ports:
- phy_clk  in  1  60 MHz ULPI clock; the only clock.
- reset_n  in  1  reset, synchronous, active-low.
- req_valid  in  NUM_REQ  per-requester request, level; held until that requester's req_done.
- req_wr  in  NUM_REQ  1 = register write, 0 = register read.
- req_addr  in  6*NUM_REQ  immediate register address; slice i = [6i+5:6i].
- req_wdata  in  8*NUM_REQ  write data; slice i = [8i+7:8i].
- req_done  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- resp_rdata  out  8  read data, valid while req_done is high.
- resp_err  out  1  timeout flag, valid while req_done is high.
- phy_busy  in  1  packet TX/RX in progress; blocks new grants.
- reg_req  out  1  command strobe to the ULPI core; level, held until ack or timeout.
- reg_wr  out  1  latched direction.
- reg_addr  out  6  latched address.
- reg_wdata  out  8  latched write data.
- reg_ack  in  1  single-cycle completion from the ULPI core.
- reg_rdata  in  8  read value, valid with reg_ack.
- arb_busy  out  1  high in any state other than IDLE.
- grant_id  out  3  index of the current or last granted requester.

Behaviour:
- All outputs are registered.
- Reset values: req_done=0, resp_rdata=0, resp_err=0, reg_req=0, reg_wr=0, reg_addr=0, reg_wdata=0, arb_busy=0, grant_id=0, timeout counter=0.
- Reset sets the round-robin pointer to NUM_REQ-1, so requester 0 wins first after reset.
- Reset mid-transaction: everything is reinitialised on that clock edge; no req_done is emitted for the aborted request.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - Requires phy_busy=0 and req_valid != 0.
  - Grant goes to the first set bit searching upward from pointer+1, wrapping modulo NUM_REQ.
  - On grant, latch req_wr, req_addr and req_wdata of the winner into reg_wr, reg_addr and reg_wdata.
  - On the same edge: set grant_id and the pointer to the winner, set reg_req=1, clear the counter, go to ISSUE.
  - Grant latency: reg_req is high 1 cycle after req_valid is seen in IDLE.
  - If phy_busy=1, stay in IDLE with no grant, regardless of req_valid.
- ISSUE:
  - reg_req stays high.
  - On reg_ack=1: reg_req<=0, resp_rdata<=(reg_wr ? 8'h00 : reg_rdata), resp_err<=0, req_done[grant_id]<=1, go to RESP.
  - Otherwise the counter increments.
  - When counter==TIMEOUT-1 with no ack: reg_req<=0, resp_rdata<=0, resp_err<=1, req_done[grant_id]<=1, go to RESP.
  - If reg_ack and timeout happen in the same cycle, ack wins (resp_err=0).
  - phy_busy is ignored in ISSUE; the ULPI core sequences the bus itself.
- RESP:
  - req_done is high for exactly this cycle; resp_rdata and resp_err are valid.
  - Next state is IDLE; req_done<=0.
  - The requester must drop req_valid on the edge where it samples req_done, so it is not re-granted.
  - IDLE grants no earlier than the cycle after RESP. Minimum back-to-back spacing is therefore 3 cycles (IDLE, ISSUE, RESP) plus the ack latency.
- reg_ack outside ISSUE is ignored; no state change and no done pulse.
- The timeout counter saturates and never wraps.
- Changes to req_valid or data of a non-granted requester while busy have no effect. The granted requester's fields are already latched, so later changes on its inputs are ignored.

Test Plan:
- Single read: req_valid=001, req_wr[0]=0, addr 0x04; core acks after 5 cycles with rdata=0x41 -> reg_req high 1 cycle after request, high for 6 cycles; req_done=001 for 1 cycle, resp_rdata=0x41, resp_err=0.
- Round-robin: req_valid=111 held, each requester dropping after its own done; core acks after 2 cycles -> grant order 0,1,2; if requester 0 immediately re-requests, order is 0,1,2,0; no requester is granted twice in a row while others wait.
- Timeout: TIMEOUT=8, requester 2 write to 0x0A, no ack -> reg_req high 8 cycles then 0; req_done=100, resp_err=1, resp_rdata=0x00; next request proceeds normally.
- Packet block: phy_busy=1 with req_valid=010 for 20 cycles -> reg_req stays 0 and arb_busy=0; phy_busy falls -> reg_req=1 one cycle later with requester 1's addr/data.
- Boundaries: ack on the same cycle as timeout -> resp_err=0. Stray reg_ack in IDLE -> no req_done. reset_n low during ISSUE -> next cycle reg_req=0 and arb_busy=0, and requester 0 wins the first grant afterwards.

Source files
------------

// File: rtl/usb2_ulpi_reg_arb.sv
// ---------------------------------------------------------------------------
// usb2_ulpi_reg_arb
//
// Round-robin arbiter in front of the ULPI core's single register-access
// command port. It runs one PHY register read or write at a time. It does not
// start a new access while the packet layer owns the bus. Completion, read
// data and timeout status go back to the granted requester only.
//
// Ports
//   phy_clk      60 MHz ULPI clock; the only clock
//   reset_n      synchronous active-low reset
//   req_valid    per-requester request level, held until its req_done
//   req_wr       per-requester direction (1 = write)
//   req_addr     per-requester 6-bit address, slice i = [6i+5:6i]
//   req_wdata    per-requester write data, slice i = [8i+7:8i]
//   req_done     one-cycle completion pulse to the granted requester
//   resp_rdata   read data, valid with req_done
//   resp_err     timeout flag, valid with req_done
//   phy_busy     packet TX/RX in progress; blocks new grants
//   reg_req      command strobe to the ULPI core, held until ack/timeout
//   reg_wr       latched direction
//   reg_addr     latched address
//   reg_wdata    latched write data
//   reg_ack      single-cycle completion from the ULPI core
//   reg_rdata    read value from the core, valid with reg_ack
//   arb_busy     high whenever the arbiter is not idle
//   grant_id     index of the current or last granted requester
// ---------------------------------------------------------------------------
module usb2_ulpi_reg_arb #(
    parameter int NUM_REQ = 3,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic                 phy_clk,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ-1:0]   req_wr,
    input  logic [6*NUM_REQ-1:0] req_addr,
    input  logic [8*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]   req_done,
    output logic [7:0]           resp_rdata,
    output logic                 resp_err,
    input  logic                 phy_busy,
    output logic                 reg_req,
    output logic                 reg_wr,
    output logic [5:0]           reg_addr,
    output logic [7:0]           reg_wdata,
    input  logic                 reg_ack,
    input  logic [7:0]           reg_rdata,
    output logic                 arb_busy,
    output logic [2:0]           grant_id
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0] CNT_MAX = {TO_W{1'b1}};
    localparam logic [2:0]      PTR_RST = 3'(NUM_REQ - 1);

    // Requester fields padded out to 8 entries so a 3-bit index always fits
    // exactly; unused entries read as zero.
    logic [7:0] valid_pad;
    logic [7:0] wr_pad;
    logic [5:0] addr_arr  [8];
    logic [7:0] wdata_arr [8];

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_unpack
            if (gi < NUM_REQ) begin : g_used
                assign valid_pad[gi] = req_valid[gi];
                assign wr_pad[gi]    = req_wr[gi];
                assign addr_arr[gi]  = req_addr[6*gi +: 6];
                assign wdata_arr[gi] = req_wdata[8*gi +: 8];
            end else begin : g_unused
                assign valid_pad[gi] = 1'b0;
                assign wr_pad[gi]    = 1'b0;
                assign addr_arr[gi]  = 6'd0;
                assign wdata_arr[gi] = 8'd0;
            end
        end
    endgenerate

    state_t               state_reg, state_next;
    logic [2:0]           ptr_reg, ptr_next;
    logic [TO_W-1:0]      cnt_reg, cnt_next;
    logic [2:0]           grant_reg, grant_next;
    logic                 req_reg, req_next;
    logic                 wr_reg, wr_next;
    logic [5:0]           addr_reg, addr_next;
    logic [7:0]           wdata_reg, wdata_next;
    logic [NUM_REQ-1:0]   done_reg, done_next;
    logic [7:0]           rdata_reg, rdata_next;
    logic                 err_reg, err_next;
    logic                 busy_reg;

    // Round-robin search: the first requesting index above the pointer wins,
    // wrapping modulo NUM_REQ. The pointer itself is examined last.
    logic       win_found;
    logic [2:0] win_idx;
    logic [3:0] cand;

    always_comb begin
        win_found = 1'b0;
        win_idx   = 3'd0;
        cand      = 4'd0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, ptr_reg} + 4'(k);
            if (cand >= 4'(NUM_REQ)) begin
                cand = cand - 4'(NUM_REQ);
            end
            if (!win_found && valid_pad[cand[2:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[2:0];
            end
        end
    end

    logic [7:0] done_onehot;

    always_comb begin
        state_next  = state_reg;
        ptr_next    = ptr_reg;
        cnt_next    = cnt_reg;
        grant_next  = grant_reg;
        req_next    = req_reg;
        wr_next     = wr_reg;
        addr_next   = addr_reg;
        wdata_next  = wdata_reg;
        done_next   = done_reg;
        rdata_next  = rdata_reg;
        err_next    = err_reg;
        done_onehot = 8'(1) << grant_reg;

        case (state_reg)
            IDLE: begin
                done_next = '0;
                if (!phy_busy && win_found) begin
                    grant_next = win_idx;
                    ptr_next   = win_idx;
                    wr_next    = wr_pad[win_idx];
                    addr_next  = addr_arr[win_idx];
                    wdata_next = wdata_arr[win_idx];
                    req_next   = 1'b1;
                    cnt_next   = '0;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                // Ack is tested first so it wins over a coincident timeout.
                if (reg_ack) begin
                    req_next   = 1'b0;
                    rdata_next = wr_reg ? 8'h00 : reg_rdata;
                    err_next   = 1'b0;
                    done_next  = done_onehot[NUM_REQ-1:0];
                    state_next = RESP;
                end else if (cnt_reg == TO_LAST) begin
                    req_next   = 1'b0;
                    rdata_next = 8'h00;
                    err_next   = 1'b1;
                    done_next  = done_onehot[NUM_REQ-1:0];
                    state_next = RESP;
                end else if (cnt_reg != CNT_MAX) begin
                    cnt_next = cnt_reg + TO_W'(1);
                end
            end
            RESP: begin
                done_next  = '0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge phy_clk) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            ptr_reg   <= PTR_RST;
            cnt_reg   <= '0;
            grant_reg <= 3'd0;
            req_reg   <= 1'b0;
            wr_reg    <= 1'b0;
            addr_reg  <= 6'd0;
            wdata_reg <= 8'd0;
            done_reg  <= '0;
            rdata_reg <= 8'd0;
            err_reg   <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            cnt_reg   <= cnt_next;
            grant_reg <= grant_next;
            req_reg   <= req_next;
            wr_reg    <= wr_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            done_reg  <= done_next;
            rdata_reg <= rdata_next;
            err_reg   <= err_next;
            // Registered copy of "state is not IDLE".
            busy_reg  <= (state_next != IDLE);
        end
    end

    assign req_done   = done_reg;
    assign resp_rdata = rdata_reg;
    assign resp_err   = err_reg;
    assign reg_req    = req_reg;
    assign reg_wr     = wr_reg;
    assign reg_addr   = addr_reg;
    assign reg_wdata  = wdata_reg;
    assign arb_busy   = busy_reg;
    assign grant_id   = grant_reg;

endmodule

// File: tb/tb_usb2_ulpi_reg_arb.sv
// ---------------------------------------------------------------------------
// tb_usb2_ulpi_reg_arb
//
// Bench for the ULPI register arbiter. It uses 3 requesters and a short
// timeout of 8. Inputs change on the falling edge and outputs are sampled
// there too. Expected grants and responses go into a queue when a request is
// driven. They are popped and compared when the DUT starts and ends the
// transaction.
// ---------------------------------------------------------------------------
module tb_usb2_ulpi_reg_arb;

    localparam int NREQ = 3;
    localparam int TOUT = 8;

    logic              phy_clk;
    logic              reset_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_wr;
    logic [6*NREQ-1:0] req_addr;
    logic [8*NREQ-1:0] req_wdata;
    logic [NREQ-1:0]   req_done;
    logic [7:0]        resp_rdata;
    logic              resp_err;
    logic              phy_busy;
    logic              reg_req;
    logic              reg_wr;
    logic [5:0]        reg_addr;
    logic [7:0]        reg_wdata;
    logic              reg_ack;
    logic [7:0]        reg_rdata;
    logic              arb_busy;
    logic [2:0]        grant_id;

    usb2_ulpi_reg_arb #(
        .NUM_REQ (NREQ),
        .TIMEOUT (TOUT),
        .TO_W    (8)
    ) dut (
        .phy_clk    (phy_clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_wr     (req_wr),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_done   (req_done),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .phy_busy   (phy_busy),
        .reg_req    (reg_req),
        .reg_wr     (reg_wr),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_ack    (reg_ack),
        .reg_rdata  (reg_rdata),
        .arb_busy   (arb_busy),
        .grant_id   (grant_id)
    );

    initial phy_clk = 1'b0;
    always #5 phy_clk = ~phy_clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0] gid;
        logic       wr;
        logic [5:0] addr;
        logic [7:0] wdata;
        int         hi;
        logic [2:0] done;
        logic [7:0] rdata;
        logic       err;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        int         req;
        logic       wr;
        logic [5:0] addr;
        logic [7:0] wdata;
        int         delay;     // ack in reg_req cycle delay+1; -1 = never
        logic [7:0] rd;
        int         exp_hi;
        logic [7:0] exp_rdata;
        logic       exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic wr, input logic [5:0] a, input logic [7:0] d);
        req_wr[i]          = wr;
        req_addr[6*i +: 6] = a;
        req_wdata[8*i +: 8]= d;
        req_valid[i]       = 1'b1;
    endtask

    task automatic push(input int gid, input logic wr, input logic [5:0] a, input logic [7:0] d,
                        input int hi, input logic [7:0] rdata, input logic err);
        exp_t e;
        e.gid   = 3'(gid);
        e.wr    = wr;
        e.addr  = a;
        e.wdata = d;
        e.hi    = hi;
        e.done  = 3'b001 << gid;
        e.rdata = rdata;
        e.err   = err;
        sb.push_back(e);
    endtask

    // Acts as the ULPI core for one transaction. It waits up to wait_max
    // cycles for reg_req, checks the latched command against the next
    // scoreboard entry, acks in the chosen cycle, checks the done response,
    // then drops the winner's request.
    task automatic serve(input int delay, input logic [7:0] rd, input int wait_max);
        int         w;
        int         hi;
        exp_t       e;
        logic [2:0] g;
        w = 0;
        while (!reg_req && w < wait_max) begin
            @(negedge phy_clk);
            w++;
        end
        if (!reg_req) begin
            checks++;
            errors++;
            $display("FAIL grant_wait: reg_req=0 after %0d cycles, expected 1", w);
            return;
        end
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty: grant %0d with no expected entry", grant_id);
            return;
        end
        e = sb.pop_front();
        chk("grant_id", 32'(grant_id), 32'(e.gid));
        chk("reg_wr", 32'(reg_wr), 32'(e.wr));
        chk("reg_addr", 32'(reg_addr), 32'(e.addr));
        chk("reg_wdata", 32'(reg_wdata), 32'(e.wdata));
        chk("arb_busy_issue", 32'(arb_busy), 32'd1);
        g  = grant_id;
        hi = 0;
        while (reg_req && hi < 40) begin
            hi++;
            reg_ack   = (hi == delay + 1);
            reg_rdata = rd;
            @(negedge phy_clk);
            reg_ack   = 1'b0;
        end
        chk("reg_req_cycles", 32'(hi), 32'(e.hi));
        chk("req_done", 32'(req_done), 32'(e.done));
        chk("resp_rdata", 32'(resp_rdata), 32'(e.rdata));
        chk("resp_err", 32'(resp_err), 32'(e.err));
        req_valid[g[1:0]] = 1'b0;
        @(negedge phy_clk);
        chk("req_done_clear", 32'(req_done), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        req_valid = '0;
        req_wr    = '0;
        req_addr  = '0;
        req_wdata = '0;
        phy_busy  = 1'b0;
        reg_ack   = 1'b0;
        reg_rdata = 8'h00;

        //               req wr addr   wdata  delay rd     hi rdata  err
        vecs[0] = '{0, 1'b0, 6'h04, 8'h00,  5, 8'h41, 6, 8'h41, 1'b0};
        vecs[1] = '{2, 1'b1, 6'h0A, 8'h5A, -1, 8'h00, 8, 8'h00, 1'b1};
        vecs[2] = '{1, 1'b0, 6'h3F, 8'h00,  0, 8'hA5, 1, 8'hA5, 1'b0};
        vecs[3] = '{2, 1'b0, 6'h15, 8'h00,  7, 8'hC3, 8, 8'hC3, 1'b0};
        vecs[4] = '{0, 1'b1, 6'h2A, 8'hFF,  3, 8'h77, 4, 8'h00, 1'b0};
        vecs[5] = '{1, 1'b1, 6'h00, 8'h81,  1, 8'h00, 2, 8'h00, 1'b0};

        // Reset state.
        repeat (3) @(negedge phy_clk);
        chk("rst_req_done", 32'(req_done), 32'd0);
        chk("rst_resp_rdata", 32'(resp_rdata), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_reg_req", 32'(reg_req), 32'd0);
        chk("rst_reg_wr", 32'(reg_wr), 32'd0);
        chk("rst_reg_addr", 32'(reg_addr), 32'd0);
        chk("rst_reg_wdata", 32'(reg_wdata), 32'd0);
        chk("rst_arb_busy", 32'(arb_busy), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        reset_n = 1'b1;
        @(negedge phy_clk);

        // Round-robin: all three requesting. Requester 0 re-requests right
        // after its done, so it has to wait behind 1 and 2.
        set_req(0, 1'b0, 6'h01, 8'h00);
        set_req(1, 1'b1, 6'h02, 8'h22);
        set_req(2, 1'b0, 6'h03, 8'h00);
        push(0, 1'b0, 6'h01, 8'h00, 3, 8'h5C, 1'b0);
        push(1, 1'b1, 6'h02, 8'h22, 3, 8'h00, 1'b0);
        push(2, 1'b0, 6'h03, 8'h00, 3, 8'h5C, 1'b0);
        push(0, 1'b0, 6'h01, 8'h00, 3, 8'h5C, 1'b0);
        @(negedge phy_clk);
        serve(2, 8'h5C, 0);
        req_valid[0] = 1'b1;
        serve(2, 8'h5C, 5);
        serve(2, 8'h5C, 5);
        serve(2, 8'h5C, 5);
        chk("rr_all_dropped", 32'(req_valid), 32'd0);

        // Single-requester vectors: read, timeout, ack on the timeout cycle,
        // and writes whose read data must come back as zero.
        for (int i = 0; i < 6; i++) begin
            set_req(vecs[i].req, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            push(vecs[i].req, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                 vecs[i].exp_hi, vecs[i].exp_rdata, vecs[i].exp_err);
            @(negedge phy_clk);
            serve(vecs[i].delay, vecs[i].rd, 0);
        end

        // Packet block: no grant while phy_busy is high.
        phy_busy = 1'b1;
        set_req(1, 1'b1, 6'h11, 8'h22);
        for (int i = 0; i < 20; i++) begin
            @(negedge phy_clk);
            chk("blk_reg_req", 32'(reg_req), 32'd0);
            chk("blk_arb_busy", 32'(arb_busy), 32'd0);
        end
        phy_busy = 1'b0;
        push(1, 1'b1, 6'h11, 8'h22, 3, 8'h00, 1'b0);
        @(negedge phy_clk);
        serve(2, 8'h99, 0);

        // Stray ack while idle.
        reg_ack   = 1'b1;
        reg_rdata = 8'hFF;
        @(negedge phy_clk);
        reg_ack   = 1'b0;
        chk("stray_req_done", 32'(req_done), 32'd0);
        chk("stray_arb_busy", 32'(arb_busy), 32'd0);
        chk("stray_reg_req", 32'(reg_req), 32'd0);
        @(negedge phy_clk);
        chk("stray_req_done2", 32'(req_done), 32'd0);

        // Reset in the middle of an access by requester 1.
        set_req(1, 1'b0, 6'h33, 8'h00);
        @(negedge phy_clk);
        chk("rstmid_reg_req", 32'(reg_req), 32'd1);
        chk("rstmid_grant", 32'(grant_id), 32'd1);
        repeat (2) @(negedge phy_clk);
        reset_n = 1'b0;
        @(negedge phy_clk);
        chk("rstmid_reg_req_low", 32'(reg_req), 32'd0);
        chk("rstmid_arb_busy", 32'(arb_busy), 32'd0);
        chk("rstmid_req_done", 32'(req_done), 32'd0);
        chk("rstmid_grant_rst", 32'(grant_id), 32'd0);
        set_req(0, 1'b1, 6'h05, 8'h3C);
        reset_n = 1'b1;
        push(0, 1'b1, 6'h05, 8'h3C, 2, 8'h00, 1'b0);
        push(1, 1'b0, 6'h33, 8'h00, 2, 8'hE7, 1'b0);
        @(negedge phy_clk);
        serve(1, 8'hE7, 0);
        serve(1, 8'hE7, 5);

        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
